// File: rtl/pselect_pkg.sv
// Shared types and helpers for the circular
// multi-grant priority selector.
package pselect_pkg;

  typedef enum logic {
    PSEL_UP   = 1'b0,
    PSEL_DOWN = 1'b1
  } psel_dir_e;

  function automatic int circ_step(
    input int        idx,
    input psel_dir_e dir,
    input int        n
  );
    if (dir == PSEL_UP) begin
      return (idx >= n - 1) ? 0 : idx + 1;
    end
    return (idx <= 0) ? n - 1 : idx - 1;
  endfunction

endpackage

// File: rtl/circ_multi_pselect.sv
// Combinational circular search for up to W
// requesters, plus a one-hot to binary encoder.
module onehot_to_binary #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  oh,
  output logic [IW-1:0] bin
);

  // OR of the indices of all set bits
  always_comb begin
    bin = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) bin = bin | IW'(i);
    end
  end

endmodule

module circ_multi_pselect
  import pselect_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int W  = 2,
  parameter  int DIR = 0,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [IW-1:0]   base,
  input  logic [N-1:0]    elig,
  output logic [W-1:0]    valid,
  output logic [W*IW-1:0] idx
);

  localparam psel_dir_e DE =
    (DIR != 0) ? PSEL_DOWN : PSEL_UP;

  logic [N-1:0]  rot;
  logic [N-1:0]  oh  [W];
  logic [IW-1:0] off [W];

  // rotate so bit j is the j-th index in search order
  always_comb begin
    rot = '0;
    for (int j = 0; j < N; j++) begin
      int p;
      if (DE == PSEL_UP) begin
        p = int'(base) + j;
        if (p >= N) p = p - N;
      end else begin
        p = int'(base) - j;
        if (p < 0) p = p + N;
      end
      rot[j] = elig[p[IW-1:0]];
    end
  end

  // peel off the lowest remaining bit once per slot
  always_comb begin
    logic [N-1:0] m;
    m = rot;
    for (int k = 0; k < W; k++) begin
      oh[k]    = m & (~m + N'(1));
      valid[k] = |m;
      m        = m & ~oh[k];
    end
  end

  for (genvar k = 0; k < W; k++) begin : g_enc
    onehot_to_binary #(
      .N  (N),
      .IW (IW)
    ) u_enc (
      .oh  (oh[k]),
      .bin (off[k])
    );
  end

  // map rotated offsets back to buffer indices
  always_comb begin
    idx = '0;
    for (int k = 0; k < W; k++) begin
      int q;
      if (DE == PSEL_UP) begin
        q = int'(base) + int'(off[k]);
        if (q >= N) q = q - N;
      end else begin
        q = int'(base) - int'(off[k]);
        if (q < 0) q = q + N;
      end
      if (valid[k]) idx[k*IW +: IW] = q[IW-1:0];
    end
  end

endmodule

// File: rtl/multi_binary_pselect_rr.sv
// Registered multi-grant circular selector with
// rotating head pointer and valid/ready output.
module multi_binary_pselect_rr
  import pselect_pkg::*;
#(
  parameter  int N   = 8,
  parameter  int W   = 2,
  parameter  int DIR = 0,
  localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            en,
  input  logic            ptr_load,
  input  logic [IW-1:0]   ptr_load_val,
  input  logic            out_ready,
  output logic [W-1:0]    out_valid,
  output logic [W*IW-1:0] gnt_idx,
  output logic [IW-1:0]   ptr
);

  localparam psel_dir_e DE =
    (DIR != 0) ? PSEL_DOWN : PSEL_UP;

  logic            any_v;
  logic            accept;
  logic            load;
  logic [IW-1:0]   last;
  logic [IW-1:0]   adv;
  logic [IW-1:0]   base;
  logic [N-1:0]    held;
  logic [N-1:0]    elig;
  logic [W-1:0]    nv;
  logic [W*IW-1:0] nidx;

  assign any_v  = |out_valid;
  assign accept = out_ready & any_v;
  assign load   = en & (~any_v | out_ready);

  // footprint and tail of the slots being held
  always_comb begin
    last = '0;
    held = '0;
    for (int k = 0; k < W; k++) begin
      if (out_valid[k]) begin
        last = gnt_idx[k*IW +: IW];
        held[gnt_idx[k*IW +: IW]] = 1'b1;
      end
    end
  end

  assign adv  = IW'(circ_step(int'(last), DE, N));
  assign base = accept ? adv : ptr;
  assign elig = req & ~(accept ? held : '0);

  circ_multi_pselect #(
    .N   (N),
    .W   (W),
    .DIR (DIR)
  ) u_sel (
    .base  (base),
    .elig  (elig),
    .valid (nv),
    .idx   (nidx)
  );

  // squash beats capture beats drain beats stall
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= '0;
      gnt_idx   <= '0;
      ptr       <= '0;
    end else if (ptr_load) begin
      out_valid <= '0;
      gnt_idx   <= '0;
      ptr       <= ptr_load_val;
    end else if (load) begin
      out_valid <= nv;
      gnt_idx   <= nidx;
      if (accept) ptr <= adv;
    end else if (out_ready) begin
      out_valid <= '0;
      gnt_idx   <= '0;
      if (accept) ptr <= adv;
    end
  end

endmodule
